tpu_load_run_ctrl: RTL and testbench
====================================

// Module: tpu_load_run_ctrl
// PURPOSE
//  Sequencer for the TPU test wrapper. On start it writes num_rows rows into BRAM A and B
//  through the external BRAM ports, stepping the random data generators once per row.
//  It then issues one APB write to the TPU start register and polls the status register
//  over APB until the done bit sets. One controller drives both BRAM ports and the APB slave.
// PARAMETERS
//  AWIDTH          11      BRAM address width
//  DESIGN_SIZE     32      byte lanes per BRAM row (width of we vectors)
//  REG_ADDRWIDTH   8       APB address width
//  REG_DATAWIDTH   32      APB data width
//  START_ADDR      8'h00   APB address of TPU start register
//  START_DATA      32'h1   value written to start the TPU
//  STATUS_ADDR     8'h00   APB address polled for completion
//  DONE_BIT        31      bit index of done flag in STATUS_ADDR read data
//  TIMEOUT_POLLS   1024    poll limit (only with TPU_LOAD_TIMEOUT_EN)
// PORTS
//  clk            in   1              single clock
//  resetn         in   1              asynchronous active-low reset
//  start          in   1              one-cycle request, sampled only in IDLE
//  base_addr_a    in   AWIDTH         first row address, BRAM A
//  base_addr_b    in   AWIDTH         first row address, BRAM B
//  num_rows       in   AWIDTH+1       rows to load (0..2^AWIDTH)
//  busy           out  1              high from the cycle after start until DONE
//  done           out  1              one-cycle pulse at end of sequence
//  error          out  1              timeout flag, valid with done
//  rng_advance    out  1              steps both random generators, one per loaded row
//  bram_addr_a    out  AWIDTH         external BRAM A address
//  bram_we_a      out  DESIGN_SIZE    external BRAM A byte write enables
//  bram_addr_b    out  AWIDTH         external BRAM B address
//  bram_we_b      out  DESIGN_SIZE    external BRAM B byte write enables
//  PADDR/PWRITE/PSEL/PENABLE/PWDATA  out  APB master request
//  PRDATA         in   REG_DATAWIDTH  APB read data
//  PREADY         in   1              APB ready
// BEHAVIOUR
//  - Reset: state IDLE. All outputs 0, including addresses, we, PSEL, PENABLE and busy/done/error.
//  - States: IDLE -> LOAD -> WR_SETUP -> WR_ACCESS -> RD_SETUP -> RD_ACCESS -> DONE -> IDLE.
//  - IDLE: on start, latch base addresses and num_rows, then go to LOAD.
//    If num_rows==0, go straight to WR_SETUP with no BRAM writes.
//  - LOAD: one row per cycle, num_rows cycles.
//    - Each cycle: bram_we_a=bram_we_b=all ones, rng_advance=1.
//    - Addresses are base+k for k=0..num_rows-1, modulo 2^AWIDTH (wraps).
//    - we and rng_advance fall to 0 in the cycle after the last row.
//  - WR_SETUP: one cycle. PSEL=1, PENABLE=0, PWRITE=1, PADDR=START_ADDR, PWDATA=START_DATA.
//  - WR_ACCESS: PSEL=1, PENABLE=1. Hold all APB outputs stable while PREADY=0.
//    Leave on PREADY=1.
//  - RD_SETUP/RD_ACCESS: same handshake with PWRITE=0, PADDR=STATUS_ADDR.
//    - On PREADY=1 with PRDATA[DONE_BIT]=1: go to DONE.
//    - Otherwise: PSEL=0 for one idle cycle, then RD_SETUP again.
//  - DONE: done=1 for one cycle, busy falls in the same cycle. Return to IDLE.
//  - start outside IDLE is ignored. No queuing.
//  - Sequence may restart the cycle after done.
//  - resetn low mid-operation: immediate return to IDLE, outputs cleared.
//    An in-flight APB transfer is abandoned.
// CONFIGURATION
//  TPU_LOAD_TIMEOUT_EN defined:
//  - A poll counter clears on each WR_ACCESS completion.
//  - After TIMEOUT_POLLS status reads without the done bit, go to DONE with error=1.
//  - error holds until the next start.
//  TPU_LOAD_TIMEOUT_EN undefined: polling is unbounded and error is tied to 0.
// TESTING
//  1. Load:   num_rows=4, base_a=0x010, base_b=0x200, PREADY=1, done bit on first read
//             -> addr_a 0x010..0x013, addr_b 0x200..0x203, we all ones for 4 cycles,
//                4 rng_advance pulses, one APB write (0x00, 0x1), one read, done pulse.
//  2. Wrap:   base_a=0x7FE, num_rows=3 -> addr_a 0x7FE, 0x7FF, 0x000.
//  3. Empty:  num_rows=0 -> no we and no rng_advance; the APB write follows start
//             after 1 cycle.
//  4. Stalls: PREADY low for 3 cycles in each access, done bit set on the 3rd read
//             -> APB outputs stable while stalled; exactly 3 reads; done after the 3rd.
//  5. Reset:  resetn low during LOAD row 2, release, start again
//             -> outputs 0 during reset; full sequence restarts from base.
//  6. Timeout (TPU_LOAD_TIMEOUT_EN, TIMEOUT_POLLS=8): status never done
//             -> 8 reads, then done=1 with error=1; start while busy has no effect.

Source files
------------

// File: rtl/tpu_load_run_ctrl.sv
// Load/run sequencer for the TPU test wrapper. It fills BRAM A/B rows, starts the TPU over APB and polls status until done.
// Optional poll timeout: define TPU_LOAD_TIMEOUT_EN (adds TIMEOUT_POLLS and drives error).
module tpu_load_run_ctrl #(
    parameter int AWIDTH        = 11,
    parameter int DESIGN_SIZE   = 32,
    parameter int REG_ADDRWIDTH = 8,
    parameter int REG_DATAWIDTH = 32,
    parameter logic [REG_ADDRWIDTH-1:0] START_ADDR  = '0,
    parameter logic [REG_DATAWIDTH-1:0] START_DATA  = 1,
    parameter logic [REG_ADDRWIDTH-1:0] STATUS_ADDR = '0,
    parameter int DONE_BIT      = 31
`ifdef TPU_LOAD_TIMEOUT_EN
    ,
    parameter int TIMEOUT_POLLS = 1024
`endif
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     start,
    input  logic [AWIDTH-1:0]        base_addr_a,
    input  logic [AWIDTH-1:0]        base_addr_b,
    input  logic [AWIDTH:0]          num_rows,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic                     rng_advance,
    output logic [AWIDTH-1:0]        bram_addr_a,
    output logic [DESIGN_SIZE-1:0]   bram_we_a,
    output logic [AWIDTH-1:0]        bram_addr_b,
    output logic [DESIGN_SIZE-1:0]   bram_we_b,
    output logic [REG_ADDRWIDTH-1:0] PADDR,
    output logic                     PWRITE,
    output logic                     PSEL,
    output logic                     PENABLE,
    output logic [REG_DATAWIDTH-1:0] PWDATA,
    input  logic [REG_DATAWIDTH-1:0] PRDATA,
    input  logic                     PREADY,
    output logic [2:0]               dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_WR_SETUP, S_WR_ACCESS, S_RD_SETUP, S_RD_ACCESS, S_RD_IDLE, S_DONE
    } state_t;

    state_t                   r_state;
    logic [AWIDTH:0]          r_rows_left;
    logic [AWIDTH-1:0]        r_addr_a;
    logic [AWIDTH-1:0]        r_addr_b;
    logic                     r_we;
    logic                     r_rng;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_psel;
    logic                     r_penable;
    logic                     r_pwrite;
    logic [REG_ADDRWIDTH-1:0] r_paddr;
    logic [REG_DATAWIDTH-1:0] r_pwdata;
    logic                     w_timeout;
    logic                     w_unused_prdata;

    // APB handshake: a transfer is one SETUP cycle (PSEL=1, PENABLE=0) followed by
    // ACCESS cycles (PSEL=1, PENABLE=1) held stable until the slave returns PREADY=1.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_rows_left <= '0;
            r_addr_a    <= '0;
            r_addr_b    <= '0;
            r_we        <= 1'b0;
            r_rng       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_busy      <= 1'b1;
                        r_addr_a    <= base_addr_a;
                        r_addr_b    <= base_addr_b;
                        r_rows_left <= num_rows;
                        if (num_rows == '0) begin
                            r_state  <= S_WR_SETUP;
                            r_psel   <= 1'b1;
                            r_pwrite <= 1'b1;
                            r_paddr  <= START_ADDR;
                            r_pwdata <= START_DATA;
                        end else begin
                            r_state <= S_LOAD;
                            r_we    <= 1'b1;
                            r_rng   <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (r_rows_left == (AWIDTH+1)'(1)) begin
                        r_we     <= 1'b0;
                        r_rng    <= 1'b0;
                        r_state  <= S_WR_SETUP;
                        r_psel   <= 1'b1;
                        r_pwrite <= 1'b1;
                        r_paddr  <= START_ADDR;
                        r_pwdata <= START_DATA;
                    end else begin
                        // Address counters wrap naturally at 2^AWIDTH.
                        r_rows_left <= r_rows_left - (AWIDTH+1)'(1);
                        r_addr_a    <= r_addr_a + AWIDTH'(1);
                        r_addr_b    <= r_addr_b + AWIDTH'(1);
                    end
                end
                S_WR_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= S_WR_ACCESS;
                end
                S_WR_ACCESS: begin
                    if (PREADY) begin
                        r_penable <= 1'b0;
                        r_pwrite  <= 1'b0;
                        r_paddr   <= STATUS_ADDR;
                        r_pwdata  <= '0;
                        r_state   <= S_RD_SETUP;
                    end
                end
                S_RD_SETUP: begin
                    r_psel    <= 1'b1;
                    r_penable <= 1'b1;
                    r_state   <= S_RD_ACCESS;
                end
                S_RD_ACCESS: begin
                    if (PREADY) begin
                        r_penable <= 1'b0;
                        r_psel    <= 1'b0;
                        if (PRDATA[DONE_BIT] || w_timeout) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_RD_IDLE;
                        end
                    end
                end
                S_RD_IDLE: begin
                    r_psel  <= 1'b1;
                    r_state <= S_RD_SETUP;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef TPU_LOAD_TIMEOUT_EN
    localparam int POLL_W = $clog2(TIMEOUT_POLLS + 1);

    logic [POLL_W-1:0] r_polls;
    logic              r_error;

    // A failing read while this is high is the last one allowed.
    assign w_timeout = (r_polls == POLL_W'(TIMEOUT_POLLS - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_polls <= '0;
            r_error <= 1'b0;
        end else begin
            if (r_state == S_IDLE && start) begin
                r_error <= 1'b0;
            end
            if (r_state == S_WR_ACCESS && PREADY) begin
                r_polls <= '0;
            end else if (r_state == S_RD_ACCESS && PREADY && !PRDATA[DONE_BIT]) begin
                r_polls <= r_polls + POLL_W'(1);
                if (w_timeout) begin
                    r_error <= 1'b1;
                end
            end
        end
    end

    assign error = r_error;
`else
    assign w_timeout = 1'b0;
    assign error     = 1'b0;
`endif

    assign w_unused_prdata = ^PRDATA;

    assign busy        = r_busy;
    assign done        = r_done;
    assign rng_advance = r_rng;
    assign bram_addr_a = r_addr_a;
    assign bram_addr_b = r_addr_b;
    assign bram_we_a   = {DESIGN_SIZE{r_we}};
    assign bram_we_b   = {DESIGN_SIZE{r_we}};
    assign PSEL        = r_psel;
    assign PENABLE     = r_penable;
    assign PWRITE      = r_pwrite;
    assign PADDR       = r_paddr;
    assign PWDATA      = r_pwdata;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_tpu_load_run_ctrl.sv
// Directed bench for tpu_load_run_ctrl: BRAM load, address wrap, empty load, APB stalls, reset abort.
// With TPU_LOAD_TIMEOUT_EN defined it also runs the poll-timeout case (TIMEOUT_POLLS=8).
module tb_tpu_load_run_ctrl;

  logic        clk;
  logic        resetn;
  logic        start;
  logic [10:0] base_addr_a;
  logic [10:0] base_addr_b;
  logic [11:0] num_rows;
  logic        busy;
  logic        done;
  logic        error;
  logic        rng_advance;
  logic [10:0] bram_addr_a;
  logic [31:0] bram_we_a;
  logic [10:0] bram_addr_b;
  logic [31:0] bram_we_b;
  logic [7:0]  PADDR;
  logic        PWRITE;
  logic        PSEL;
  logic        PENABLE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int rng_count = 0;
  int rng_mark;

  logic [10:0] exp_a_q[$];
  logic [10:0] exp_b_q[$];

`ifdef TPU_LOAD_TIMEOUT_EN
  tpu_load_run_ctrl #(.TIMEOUT_POLLS(8)) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .base_addr_a(base_addr_a), .base_addr_b(base_addr_b), .num_rows(num_rows),
    .busy(busy), .done(done), .error(error), .rng_advance(rng_advance),
    .bram_addr_a(bram_addr_a), .bram_we_a(bram_we_a),
    .bram_addr_b(bram_addr_b), .bram_we_b(bram_we_b),
    .PADDR(PADDR), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .dbg_state(dbg_state)
  );
`else
  tpu_load_run_ctrl dut (
    .clk(clk), .resetn(resetn), .start(start),
    .base_addr_a(base_addr_a), .base_addr_b(base_addr_b), .num_rows(num_rows),
    .busy(busy), .done(done), .error(error), .rng_advance(rng_advance),
    .bram_addr_a(bram_addr_a), .bram_we_a(bram_we_a),
    .bram_addr_b(bram_addr_b), .bram_we_b(bram_we_b),
    .PADDR(PADDR), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .dbg_state(dbg_state)
  );
`endif

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rng_advance === 1'b1) rng_count++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic kick(input logic [10:0] ba, input logic [10:0] bb, input logic [11:0] rows);
    base_addr_a = ba;
    base_addr_b = bb;
    num_rows    = rows;
    start       = 1'b1;
    rng_mark    = rng_count;
    tick();
    start       = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
  endtask

  task automatic load_rows(input logic [10:0] ba, input logic [10:0] bb, input int rows);
    logic [10:0] ea;
    logic [10:0] eb;
    for (int k = 0; k < rows; k++) begin
      exp_a_q.push_back(ba + 11'(k));
      exp_b_q.push_back(bb + 11'(k));
    end
    while (exp_a_q.size() > 0) begin
      ea = exp_a_q.pop_front();
      eb = exp_b_q.pop_front();
      chk("load_addr_a", 64'(bram_addr_a), 64'(ea));
      chk("load_addr_b", 64'(bram_addr_b), 64'(eb));
      chk("load_we_a", 64'(bram_we_a), 64'hFFFF_FFFF);
      chk("load_we_b", 64'(bram_we_b), 64'hFFFF_FFFF);
      chk("load_rng", 64'(rng_advance), 64'd1);
      tick();
    end
    chk("post_load_we_a", 64'(bram_we_a), 64'd0);
    chk("post_load_we_b", 64'(bram_we_b), 64'd0);
    chk("post_load_rng", 64'(rng_advance), 64'd0);
  endtask

  // Enters in the SETUP cycle; returns in the cycle after the completing ACCESS edge.
  task automatic apb_xfer(input bit wr, input int stall, input bit done_bit);
    logic [31:0] exp_wdata;
    exp_wdata = wr ? 32'h1 : 32'h0;
    chk("setup_psel", 64'(PSEL), 64'd1);
    chk("setup_penable", 64'(PENABLE), 64'd0);
    chk("setup_pwrite", 64'(PWRITE), 64'(wr));
    chk("setup_paddr", 64'(PADDR), 64'h00);
    chk("setup_pwdata", 64'(PWDATA), 64'(exp_wdata));
    PREADY = 1'b0;
    PRDATA = 32'h8000_0000;
    tick();
    for (int s = 0; s <= stall; s++) begin
      if (s == stall) begin
        PREADY = 1'b1;
        PRDATA = done_bit ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end
      chk("access_psel", 64'(PSEL), 64'd1);
      chk("access_penable", 64'(PENABLE), 64'd1);
      chk("access_pwrite", 64'(PWRITE), 64'(wr));
      chk("access_paddr", 64'(PADDR), 64'h00);
      chk("access_pwdata", 64'(PWDATA), 64'(exp_wdata));
      chk("access_busy", 64'(busy), 64'd1);
      tick();
    end
    PREADY = 1'b0;
    PRDATA = 32'h0;
  endtask

  task automatic poll_idle();
    chk("poll_idle_psel", 64'(PSEL), 64'd0);
    chk("poll_idle_penable", 64'(PENABLE), 64'd0);
    chk("poll_idle_busy", 64'(busy), 64'd1);
    chk("poll_idle_done", 64'(done), 64'd0);
    tick();
  endtask

  task automatic check_done(input bit exp_err);
    chk("done_pulse", 64'(done), 64'd1);
    chk("done_busy", 64'(busy), 64'd0);
    chk("done_error", 64'(error), 64'(exp_err));
    chk("done_psel", 64'(PSEL), 64'd0);
    tick();
    chk("idle_done", 64'(done), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_state", 64'(dbg_state), 64'd0);
    chk("idle_error", 64'(error), 64'(exp_err));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_addr_a"}, 64'(bram_addr_a), 64'd0);
    chk({tag, "_addr_b"}, 64'(bram_addr_b), 64'd0);
    chk({tag, "_we_a"}, 64'(bram_we_a), 64'd0);
    chk({tag, "_we_b"}, 64'(bram_we_b), 64'd0);
    chk({tag, "_rng"}, 64'(rng_advance), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_error"}, 64'(error), 64'd0);
    chk({tag, "_psel"}, 64'(PSEL), 64'd0);
    chk({tag, "_penable"}, 64'(PENABLE), 64'd0);
    chk({tag, "_pwrite"}, 64'(PWRITE), 64'd0);
    chk({tag, "_pwdata"}, 64'(PWDATA), 64'd0);
    chk({tag, "_state"}, 64'(dbg_state), 64'd0);
  endtask

  initial begin
    resetn = 1'b0;
    start = 1'b0;
    base_addr_a = '0;
    base_addr_b = '0;
    num_rows = '0;
    PRDATA = '0;
    PREADY = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    resetn = 1'b1;
    tick();
    check_all_zero("post_reset_idle");

    // Test 1: basic 4-row load, immediate ready, done on first read
    kick(11'h010, 11'h200, 12'd4);
    load_rows(11'h010, 11'h200, 4);
    apb_xfer(1'b1, 0, 1'b0);
    apb_xfer(1'b0, 0, 1'b1);
    check_done(1'b0);
    chk("t1_rng_pulses", 64'(rng_count - rng_mark), 64'd4);
    tick();
    chk("t1_stays_idle", 64'(PSEL), 64'd0);

    // Test 2: address wrap
    kick(11'h7FE, 11'h001, 12'd3);
    load_rows(11'h7FE, 11'h001, 3);
    apb_xfer(1'b1, 0, 1'b0);
    apb_xfer(1'b0, 0, 1'b1);
    check_done(1'b0);
    chk("t2_rng_pulses", 64'(rng_count - rng_mark), 64'd3);

    // Test 3: empty load goes straight to the APB write
    kick(11'h055, 11'h066, 12'd0);
    chk("t3_we_a", 64'(bram_we_a), 64'd0);
    chk("t3_rng", 64'(rng_advance), 64'd0);
    apb_xfer(1'b1, 0, 1'b0);
    apb_xfer(1'b0, 0, 1'b1);
    check_done(1'b0);
    chk("t3_rng_pulses", 64'(rng_count - rng_mark), 64'd0);

    // Test 4: 3 wait states per access, done on the 3rd read; start while busy ignored
    kick(11'h100, 11'h300, 12'd2);
    load_rows(11'h100, 11'h300, 2);
    apb_xfer(1'b1, 3, 1'b0);
    apb_xfer(1'b0, 3, 1'b0);
    start = 1'b1;
    poll_idle();
    apb_xfer(1'b0, 3, 1'b0);
    start = 1'b0;
    poll_idle();
    apb_xfer(1'b0, 3, 1'b1);
    check_done(1'b0);
    tick();
    chk("t4_no_extra_read", 64'(PSEL), 64'd0);
    chk("t4_no_restart", 64'(busy), 64'd0);

    // Test 5: reset during LOAD row 2, then a full restart
    kick(11'h010, 11'h200, 12'd4);
    chk("t5_row0_addr_a", 64'(bram_addr_a), 64'h010);
    tick();
    tick();
    chk("t5_row2_addr_a", 64'(bram_addr_a), 64'h012);
    resetn = 1'b0;
    #1;
    check_all_zero("t5_reset");
    tick();
    check_all_zero("t5_reset_hold");
    resetn = 1'b1;
    tick();
    check_all_zero("t5_released");
    kick(11'h010, 11'h200, 12'd4);
    load_rows(11'h010, 11'h200, 4);
    apb_xfer(1'b1, 0, 1'b0);
    apb_xfer(1'b0, 0, 1'b1);
    check_done(1'b0);

`ifdef TPU_LOAD_TIMEOUT_EN
    // Test 6: status never done, timeout after 8 reads
    kick(11'h020, 11'h040, 12'd1);
    load_rows(11'h020, 11'h040, 1);
    apb_xfer(1'b1, 0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) start = 1'b1;
      apb_xfer(1'b0, 0, 1'b0);
      start = 1'b0;
      if (i < 7) begin
        chk("t6_error_low", 64'(error), 64'd0);
        poll_idle();
      end
    end
    check_done(1'b1);
    kick(11'h000, 11'h000, 12'd0);
    chk("t6_error_cleared", 64'(error), 64'd0);
    apb_xfer(1'b1, 0, 1'b0);
    apb_xfer(1'b0, 0, 1'b1);
    check_done(1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
